fetch_stage: RTL
================

Name: fetch_stage

Overview:
IF stage of the 5-stage RV32I pipeline and producer side of the decode-stage input (InstrD, PCD, PCplus4D).
- Owns the PC and issues in-order instruction-memory requests over a valid/ready request channel.
- Buffers returned instructions with their PCs and presents them through the IF/ID pipeline register.
- Honours decode stall, and on branch/jump redirect discards wrong-path instructions, including responses still in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
IBUF_DEPTH, 2, instruction buffer entries; caps outstanding + buffered instructions.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  instruction returned (in order, no backpressure)
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  taken branch/jump from execute
redirect_pc  in  32  redirect target
StallD  in  1  decode holds the IF/ID register
InstrD  out  32  instruction to decode
PCD  out  32  PC of InstrD
PCplus4D  out  32  PCD+4
ValidD  out  1  InstrD is real; 0 = poisoned bubble

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset state:
  - pc_f=RESET_PC; outstanding=0; drop_cnt=0; ibuf empty.
  - ValidD=0, InstrD=32'h0000_0013 (NOP), PCD=0, PCplus4D=0, imem_req_valid=0 during reset.
  - imem is reset by the same rst; no pre-reset responses arrive afterwards.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (outstanding + ibuf_count < IBUF_DEPTH); imem_req_addr=pc_f.
  - Accept when valid&&ready: push pc_f to in-flight PC queue (depth IBUF_DEPTH); pc_f+=4 (mod 2^32, wraps 0xFFFF_FFFC -> 0); outstanding+1.
  - While ready is low, addr and pc_f are held; valid may drop only on redirect.
- Response:
  - Pop PC queue; outstanding-1.
  - drop_cnt>0: discard response, drop_cnt-1.
  - Otherwise the {instr,pc} entry goes to the IF/ID register if ibuf is empty and IF/ID can load (bypass); else it is pushed to ibuf.
  - The credit rule guarantees ibuf never overflows.
  - A response with outstanding=0 is illegal; assert.
- IF/ID register:
  - Loads when !StallD || !ValidD. Source: ibuf head (pop) if non-empty, else bypassed response; if neither, ValidD<=0 and InstrD<=NOP.
  - Loaded: InstrD=instr, PCD=pc, PCplus4D=pc+4, ValidD=1.
  - StallD with ValidD=1 freezes all four outputs.
- Latency: request accepted cycle t, response cycle t+1 -> ValidD=1 in cycle t+2. Steady state is 1 instr/cycle with IBUF_DEPTH>=2 and 1-cycle imem.
- Redirect (priority over StallD and responses):
  - Next-cycle effects: pc_f<=redirect_pc&~3; ibuf flushed; PC queue flushed.
  - IF/ID register: ValidD<=0, InstrD<=NOP.
  - drop_cnt<=outstanding minus 1 if a response arrives this cycle; that same-cycle response is also dropped.
  - No request issued in the redirect cycle; the first new request is at cycle+1.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- Counters are saturating-safe: outstanding<=IBUF_DEPTH and drop_cnt<=IBUF_DEPTH by construction.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR=32'h0000_0013.
  - typedef fetch_entry_t {logic[31:0] instr; logic[31:0] pc;}.
  - Reset-value constants.
- Sub-module fetch_ibuf: parameterised synchronous FIFO of fetch_entry_t with push/pop/flush/count. Also instantiated for the in-flight PC queue (instr field unused).

Test Plan:
1. Stream: imem ready always, 1-cycle latency, data=addr^32'hA5A5_0000 -> from cycle 3 ValidD=1 each cycle; PCD=0,4,8,...; PCplus4D=PCD+4; InstrD matches.
2. StallD high 3 cycles mid-stream at PCD=0x8 -> outputs frozen at 0x8; imem_req_valid drops when credits run out; release gives 0xC,0x10,... with no loss or duplicate.
3. Redirect to 0x100 with 2 outstanding -> next cycle ValidD=0 and InstrD=0x13; both stale responses discarded; next ValidD=1 has PCD=0x100.
4. Redirect with StallD=1 and a response in the same cycle -> redirect wins; the response is dropped; resumes at target.
5. redirect_pc=0x103 -> imem_req_addr=0x100. Separately, pc_f at 0xFFFF_FFFC -> next addr 0x0.
6. imem_req_ready low 5 cycles -> imem_req_addr stable, no PC advance. Then rst asserted mid-stream -> all outputs at reset values next cycle; refetch from RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Imported by the fetch stage top and its FIFO sub-module.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] RST_PCD   = 32'h0000_0000;
  localparam logic [31:0] RST_PCP4  = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam fetch_entry_t RST_ENTRY = '{
    instr: NOP_INSTR,
    pc:    RST_PCD
  };

  function automatic int unsigned cnt_w(
    input int unsigned depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Small synchronous FIFO of fetch entries with flush.
// Used both as instruction buffer and in-flight PC queue.
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  din_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  // a full buffer may still accept when it pops in the same cycle
  assign do_push = push_i &&
                   ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) begin
      mem_q[wr_q] <= din_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues imem requests, buffers
// responses and drives the IF/ID register toward decode.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        StallD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCplus4D,
  output logic        ValidD
);

  localparam int unsigned CW = cnt_w(IBUF_DEPTH);
  localparam logic [CW:0] CREDITS = (CW+1)'(IBUF_DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   pc4_q, pc4_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          valid_q, valid_d;
  fetch_entry_t  ifid_q, ifid_d;

  logic [CW-1:0] ibuf_cnt, pcq_cnt;
  fetch_entry_t  ibuf_head, pcq_head, rsp_entry;
  fetch_entry_t  pcq_din;
  logic [CW:0]   credit_used;
  logic          req_fire, rsp_live, ifid_ld;
  logic          ibuf_push, ibuf_pop, pcq_pop;
  logic          unused_pcq_instr;

  assign credit_used = {1'b0, outst_q} +
                       {1'b0, ibuf_cnt};

  assign imem_req_valid = !rst && !redirect_valid &&
                          (credit_used < CREDITS);
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign pcq_pop  = imem_rsp_valid && (drop_q == '0);
  assign rsp_live = pcq_pop && !redirect_valid;
  assign ifid_ld  = !StallD || !valid_q;

  assign pcq_din   = '{instr: NOP_INSTR, pc: pc_q};
  assign rsp_entry = '{instr: imem_rsp_data,
                       pc:    pcq_head.pc};
  assign unused_pcq_instr = ^pcq_head.instr;

  fetch_ibuf #(.DEPTH(IBUF_DEPTH), .CW(CW)) u_pcq (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .din_i   (pcq_din),
    .pop_i   (pcq_pop),
    .head_o  (pcq_head),
    .count_o (pcq_cnt)
  );

  fetch_ibuf #(.DEPTH(IBUF_DEPTH), .CW(CW)) u_ibuf (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (ibuf_push),
    .din_i   (rsp_entry),
    .pop_i   (ibuf_pop),
    .head_o  (ibuf_head),
    .count_o (ibuf_cnt)
  );

  always_comb begin
    ibuf_push = 1'b0;
    ibuf_pop  = 1'b0;
    ifid_d    = ifid_q;
    valid_d   = valid_q;
    pc4_d     = pc4_q;
    priority case (1'b1)
      redirect_valid: begin
        valid_d      = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
      !ifid_ld: begin
        ibuf_push = rsp_live;
      end
      (ibuf_cnt != '0): begin
        ibuf_pop  = 1'b1;
        ibuf_push = rsp_live;
        ifid_d    = ibuf_head;
        valid_d   = 1'b1;
        pc4_d     = ibuf_head.pc + 32'd4;
      end
      rsp_live: begin
        ifid_d  = rsp_entry;
        valid_d = 1'b1;
        pc4_d   = rsp_entry.pc + 32'd4;
      end
      default: begin
        valid_d      = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(req_fire) -
              CW'(imem_rsp_valid);
    priority case (1'b1)
      redirect_valid: pc_d = redirect_pc & ~32'h3;
      req_fire:       pc_d = pc_q + 32'd4;
      default:        pc_d = pc_q;
    endcase
    // stale responses still in flight must be discarded
    if (redirect_valid) begin
      drop_d = outst_q - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && drop_q != '0) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      pc4_q   <= RST_PCP4;
      outst_q <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      ifid_q  <= RST_ENTRY;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      ifid_q  <= ifid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!imem_rsp_valid || outst_q != '0);
      assert (pcq_cnt <= outst_q);
    end
  end

  assign InstrD   = ifid_q.instr;
  assign PCD      = ifid_q.pc;
  assign PCplus4D = pc4_q;
  assign ValidD   = valid_q;

endmodule
